rv32_multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the RV32 datapath. It sequences fetch, decode, execute, memory and writeback for a defined RV32I subset. It drives the ALU opcode using the existing 3-bit ALU encoding, plus all datapath mux selects and write strobes. It is the producer side of the ALU control interface and the initiator on the unified instruction/data memory port.

---
 rtl/rv32_multicycle_ctrl.sv | 272 +++++++++++++++++++++++++++
 tb/tb_rv32_multicycle_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_multicycle_ctrl.sv
// rv32_multicycle_ctrl
//   Multi-cycle control FSM for the RV32 datapath. It sequences fetch, decode,
//   execute, memory and writeback for a small RV32I subset: lw, sw, R-type and
//   I-type ALU ops, beq and jal. It drives the 3-bit ALU opcode, every datapath
//   mux select and write strobe, and it is the initiator on the unified memory port.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   instr[31:0]           instruction register contents, valid from DECODE on
//   zero                  ALU result == 0, used by beq
//   mem_ready             memory completes the outstanding request this cycle
//   mem_req, mem_write    memory request and store qualifier
//   adr_src               memory address select (0 PC, 1 ALUOut)
//   ir_write, pc_write    instruction register / PC load strobes
//   reg_write             register file write strobe
//   alu_src_a/b[1:0]      ALU operand selects
//   imm_src[1:0]          immediate format (I, S, B, J)
//   result_src[1:0]       result bus select (ALUOut, memory, ALU direct)
//   alu_control[2:0]      ALU operation
//   instr_done            one-cycle pulse when an instruction retires
//   illegal               sticky flag, set once an unsupported instruction is seen

module rv32_multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  imm_src,
  output logic [1:0]  result_src,
  output logic [2:0]  alu_control,
  output logic        instr_done,
  output logic        illegal
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_TRAP
  } state_t;

  state_t state_q, state_d;
  logic   illegal_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic       unusedInstrBits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign f7b5   = instr[30];

  // Register numbers and the rest of the immediate only matter to the datapath.
  assign unusedInstrBits = ^{instr[31], instr[29:15], instr[11:7]};

  // Raw FSM outputs before the reset gate on the strobes.
  logic       memReqFsm, memWriteFsm, irWriteFsm, pcWriteFsm, regWriteFsm, doneFsm;
  logic       adrSrcFsm;
  logic [1:0] aluSrcAFsm, aluSrcBFsm, immSrcFsm, resultSrcFsm;
  logic [2:0] aluCtlFsm;

  // ALU op decode shared by R-type and I-type execute. The two only differ in
  // funct3=000: R-type uses funct7[5] to pick SUB, I-type is always ADD (that
  // bit is part of the immediate there). SRA/SRAI and SLTU are not supported.
  logic [2:0] rAluOp, iAluOp;
  logic       rBad, iBad;

  always_comb begin
    rAluOp = ALU_ADD;
    rBad   = 1'b0;
    unique case (funct3)
      3'b000: rAluOp = f7b5 ? ALU_SUB : ALU_ADD;
      3'b111: rAluOp = ALU_AND;
      3'b110: rAluOp = ALU_OR;
      3'b100: rAluOp = ALU_XOR;
      3'b001: rAluOp = ALU_SLL;
      3'b101: begin
        if (f7b5) rBad = 1'b1;
        else      rAluOp = ALU_SRL;
      end
      3'b010: rAluOp = ALU_SLT;
      3'b011: rBad = 1'b1;
      default: rBad = 1'b1;
    endcase
    iAluOp = (funct3 == 3'b000) ? ALU_ADD : rAluOp;
    iBad   = rBad;
  end

  // Immediate format follows the opcode; anything not S/B/J uses the I layout.
  logic [1:0] immFromOpcode;

  always_comb begin
    immFromOpcode = 2'b00;
    if (opcode == OP_SW)  immFromOpcode = 2'b01;
    if (opcode == OP_BR)  immFromOpcode = 2'b10;
    if (opcode == OP_JAL) immFromOpcode = 2'b11;
  end

  // State register plus the sticky illegal flag, which latches as soon as the
  // FSM commits to TRAP and only clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | (state_d == S_TRAP);
    end
  end

  // Next-state and Moore output decode. The only input-dependent strobes are
  // ir_write/pc_write in FETCH (mem_ready), instr_done in MEMWRITE (mem_ready)
  // and pc_write in BEQ (zero).
  always_comb begin
    state_d      = state_q;
    memReqFsm    = 1'b0;
    memWriteFsm  = 1'b0;
    irWriteFsm   = 1'b0;
    pcWriteFsm   = 1'b0;
    regWriteFsm  = 1'b0;
    doneFsm      = 1'b0;
    adrSrcFsm    = 1'b0;
    aluSrcAFsm   = 2'b00;
    aluSrcBFsm   = 2'b00;
    immSrcFsm    = 2'b00;
    resultSrcFsm = 2'b00;
    aluCtlFsm    = ALU_ADD;

    unique case (state_q)
      S_FETCH: begin
        memReqFsm    = 1'b1;
        aluSrcBFsm   = 2'b10;
        resultSrcFsm = 2'b10;
        irWriteFsm   = mem_ready;
        pcWriteFsm   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        aluSrcAFsm = 2'b01;
        aluSrcBFsm = 2'b01;
        immSrcFsm  = immFromOpcode;
        if (opcode == OP_LW || opcode == OP_SW)         state_d = S_MEMADR;
        else if (opcode == OP_R)                        state_d = S_EXECR;
        else if (opcode == OP_I)                        state_d = S_EXECI;
        else if (opcode == OP_BR && funct3 == 3'b000)   state_d = S_BEQ;
        else if (opcode == OP_JAL)                      state_d = S_JAL;
        else                                            state_d = S_TRAP;
      end
      S_MEMADR: begin
        aluSrcAFsm = 2'b10;
        aluSrcBFsm = 2'b01;
        immSrcFsm  = immFromOpcode;
        state_d    = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        memReqFsm = 1'b1;
        adrSrcFsm = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultSrcFsm = 2'b01;
        regWriteFsm  = 1'b1;
        doneFsm      = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        memReqFsm   = 1'b1;
        memWriteFsm = 1'b1;
        adrSrcFsm   = 1'b1;
        doneFsm     = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        aluSrcAFsm = 2'b10;
        if (rBad) begin
          state_d = S_TRAP;
        end else begin
          aluCtlFsm = rAluOp;
          state_d   = S_ALUWB;
        end
      end
      S_EXECI: begin
        // rs1 is the first operand here as well; only operand B changes.
        aluSrcAFsm = 2'b10;
        aluSrcBFsm = 2'b01;
        if (iBad) begin
          state_d = S_TRAP;
        end else begin
          aluCtlFsm = iAluOp;
          state_d   = S_ALUWB;
        end
      end
      S_ALUWB: begin
        regWriteFsm = 1'b1;
        doneFsm     = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        aluSrcAFsm = 2'b10;
        aluCtlFsm  = ALU_SUB;
        pcWriteFsm = zero;
        doneFsm    = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // Target was computed into ALUOut during DECODE; ALU now forms oldPC+4
        // for the link write in ALUWB.
        aluSrcAFsm = 2'b01;
        aluSrcBFsm = 2'b10;
        pcWriteFsm = 1'b1;
        state_d    = S_ALUWB;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Strobes are gated with rst_n so that asserting reset kills any in-flight
  // write or memory request immediately, not at the next clock edge.
  assign mem_req     = memReqFsm   & rst_n;
  assign mem_write   = memWriteFsm & rst_n;
  assign ir_write    = irWriteFsm  & rst_n;
  assign pc_write    = pcWriteFsm  & rst_n;
  assign reg_write   = regWriteFsm & rst_n;
  assign instr_done  = doneFsm     & rst_n;
  assign adr_src     = adrSrcFsm;
  assign alu_src_a   = aluSrcAFsm;
  assign alu_src_b   = aluSrcBFsm;
  assign imm_src     = immSrcFsm;
  assign result_src  = resultSrcFsm;
  assign alu_control = aluCtlFsm;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// tb_rv32_multicycle_ctrl
//   Directed bench for the multi-cycle control FSM. Each step pushes the
//   expected per-cycle outputs (and the mem_ready/zero to drive that cycle)
//   onto a scoreboard queue, then applyStimulus drains it one clock at a time.

module tb_rv32_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]  alu_src_a, alu_src_b, imm_src, result_src;
  logic [2:0]  alu_control;
  logic        instr_done, illegal;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND_OP = 3'b010;
  localparam logic [2:0] SRL = 3'b110;
  localparam logic [2:0] SLT = 3'b111;

  // Packed layout: mem_req mem_write adr_src ir_write pc_write reg_write
  // instr_done illegal | alu_src_a alu_src_b imm_src result_src | alu_control
  localparam logic [18:0] MASK_ALL    = 19'h7FFFF;
  localparam logic [18:0] MASK_STROBE = 19'h7F800;
  localparam logic [18:0] MASK_NOIMM  = 19'h7FF9F;
  localparam logic [18:0] MASK_NOA    = 19'h7F9FF;
  localparam logic [18:0] MASK_NOALU  = 19'h7FFF8;

  typedef struct {
    string       tag;
    logic        ready;
    logic        zeroIn;
    logic [18:0] val;
    logic [18:0] mask;
  } expT;

  expT sb[$];

  rv32_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .result_src(result_src), .alu_control(alu_control),
    .instr_done(instr_done), .illegal(illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [18:0] pack(logic mr, logic mw, logic as, logic iw,
                                       logic pw, logic rw, logic dn, logic il,
                                       logic [1:0] a, logic [1:0] b,
                                       logic [1:0] im, logic [1:0] rs,
                                       logic [2:0] al);
    return {mr, mw, as, iw, pw, rw, dn, il, a, b, im, rs, al};
  endfunction

  task automatic pushExp(string tag, logic rdy, logic z, logic [18:0] v, logic [18:0] m);
    expT e;
    e.tag = tag; e.ready = rdy; e.zeroIn = z; e.val = v; e.mask = m;
    sb.push_back(e);
  endtask

  // Expected outputs per state, written straight from the state table.
  task automatic expFetch(logic rdy);
    pushExp("FETCH", rdy, 1'b0, pack(1,0,0,rdy,rdy,0,0,0, 2'b00,2'b10,2'b00,2'b10, ADD), MASK_ALL);
  endtask
  task automatic expDecode(logic [1:0] im);
    pushExp("DECODE", 1'b0, 1'b0, pack(0,0,0,0,0,0,0,0, 2'b01,2'b01,im,2'b00, ADD), MASK_ALL);
  endtask
  task automatic expMemAdr();
    pushExp("MEMADR", 1'b0, 1'b0, pack(0,0,0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, ADD), MASK_NOIMM);
  endtask
  task automatic expMemRead(logic rdy);
    pushExp("MEMREAD", rdy, 1'b0, pack(1,0,1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, ADD), MASK_ALL);
  endtask
  task automatic expMemWb();
    pushExp("MEMWB", 1'b0, 1'b0, pack(0,0,0,0,0,1,1,0, 2'b00,2'b00,2'b00,2'b01, ADD), MASK_ALL);
  endtask
  task automatic expMemWrite(logic rdy);
    pushExp("MEMWRITE", rdy, 1'b0, pack(1,1,1,0,0,0,rdy,0, 2'b00,2'b00,2'b00,2'b00, ADD), MASK_ALL);
  endtask
  task automatic expExecR(logic [2:0] op);
    pushExp("EXECR", 1'b0, 1'b0, pack(0,0,0,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b00, op), MASK_ALL);
  endtask
  task automatic expExecRTrap();
    pushExp("EXECR_BAD", 1'b0, 1'b0, pack(0,0,0,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b00, ADD), MASK_NOALU);
  endtask
  task automatic expExecI(logic [2:0] op);
    pushExp("EXECI", 1'b0, 1'b0, pack(0,0,0,0,0,0,0,0, 2'b00,2'b01,2'b00,2'b00, op), MASK_NOA);
  endtask
  task automatic expAluWb();
    pushExp("ALUWB", 1'b0, 1'b0, pack(0,0,0,0,0,1,1,0, 2'b00,2'b00,2'b00,2'b00, ADD), MASK_ALL);
  endtask
  task automatic expBeq(logic z);
    pushExp("BEQ", 1'b0, z, pack(0,0,0,0,z,0,1,0, 2'b10,2'b00,2'b00,2'b00, SUB), MASK_ALL);
  endtask
  task automatic expJal();
    pushExp("JAL", 1'b0, 1'b0, pack(0,0,0,0,1,0,0,0, 2'b01,2'b10,2'b00,2'b00, ADD), MASK_ALL);
  endtask
  task automatic expTrap();
    // Drive mem_ready and zero high so a leaking gated strobe would show.
    pushExp("TRAP", 1'b1, 1'b1, pack(0,0,0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, ADD), MASK_ALL);
  endtask

  task automatic checkOutput(expT e);
    logic [18:0] obs, expected, observed;
    obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, instr_done,
           illegal, alu_src_a, alu_src_b, imm_src, result_src, alu_control};
    observed = obs & e.mask;
    expected = e.val & e.mask;
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", e.tag, observed, expected);
    end
  endtask

  // Drive one instruction and drain the scoreboard, one entry per clock.
  // Inputs change just after the rising edge; outputs are sampled on the
  // falling edge.
  task automatic applyStimulus(logic [31:0] ins);
    expT e;
    instr = ins;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.ready;
      zero      = e.zeroIn;
      @(negedge clk);
      checkOutput(e);
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    zero      = 1'b0;
  endtask

  task automatic checkReset(string tag);
    expT e;
    e.tag = tag; e.ready = 1'b0; e.zeroIn = 1'b0; e.val = '0; e.mask = MASK_STROBE;
    checkOutput(e);
  endtask

  // Called just after a rising edge: pulse reset across one edge with mem_ready
  // high so any ungated strobe would be visible.
  task automatic doReset(string tag);
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    checkReset(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_ready = 1'b0;
  endtask

  initial begin
    expT e;
    rst_n = 1'b0;
    instr = 32'h0;
    zero = 1'b0;
    mem_ready = 1'b1;
    #12;
    checkReset("reset_hold");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // add x3,x1,x2
    expFetch(1); expDecode(2'b00); expExecR(ADD); expAluWb();
    applyStimulus(32'h002081B3);
    // sub, slt, srl, and
    expFetch(1); expDecode(2'b00); expExecR(SUB); expAluWb();
    applyStimulus(32'h402081B3);
    expFetch(1); expDecode(2'b00); expExecR(SLT); expAluWb();
    applyStimulus(32'h0020A1B3);
    expFetch(1); expDecode(2'b00); expExecR(SRL); expAluWb();
    applyStimulus(32'h0020D1B3);
    expFetch(1); expDecode(2'b00); expExecR(AND_OP); expAluWb();
    applyStimulus(32'h0020F1B3);
    // addi, and addi whose immediate has bit 30 set (still ADD)
    expFetch(1); expDecode(2'b00); expExecI(ADD); expAluWb();
    applyStimulus(32'h00500093);
    expFetch(1); expDecode(2'b00); expExecI(ADD); expAluWb();
    applyStimulus(32'h40000093);
    // lw with two wait cycles in MEMREAD: 7 cycles total
    expFetch(1); expDecode(2'b00); expMemAdr();
    expMemRead(0); expMemRead(0); expMemRead(1); expMemWb();
    applyStimulus(32'h0000A183);
    // sw with one fetch wait and one store wait
    expFetch(0); expFetch(1); expDecode(2'b01); expMemAdr();
    expMemWrite(0); expMemWrite(1);
    applyStimulus(32'h0020A223);
    // beq taken and not taken
    expFetch(1); expDecode(2'b10); expBeq(1);
    applyStimulus(32'h00208463);
    expFetch(1); expDecode(2'b10); expBeq(0);
    applyStimulus(32'h00208463);
    // jal
    expFetch(1); expDecode(2'b11); expJal(); expAluWb();
    applyStimulus(32'h008000EF);

    // sra is unsupported: trap out of EXECR
    expFetch(1); expDecode(2'b00); expExecRTrap(); expTrap(); expTrap(); expTrap();
    applyStimulus(32'h4020D1B3);
    doReset("reset_from_trap_r");

    // ecall opcode traps straight from DECODE
    expFetch(1); expDecode(2'b00); expTrap(); expTrap();
    applyStimulus(32'h00000073);
    doReset("reset_from_trap_sys");
    expFetch(1); expDecode(2'b00); expExecR(ADD); expAluWb();
    applyStimulus(32'h002081B3);

    // Reset pulse in the middle of a stalled store
    expFetch(1); expDecode(2'b01); expMemAdr();
    applyStimulus(32'h0020A223);
    mem_ready = 1'b0;
    @(negedge clk);
    e.tag = "MEMWRITE_wait"; e.ready = 1'b0; e.zeroIn = 1'b0;
    e.val = pack(1,1,1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, ADD); e.mask = MASK_ALL;
    checkOutput(e);
    #1;
    rst_n = 1'b0;
    #1;
    checkReset("reset_async_drop");
    @(posedge clk);
    #1;
    checkReset("reset_across_edge");
    rst_n = 1'b1;
    expFetch(1); expDecode(2'b01); expMemAdr(); expMemWrite(1);
    applyStimulus(32'h0020A223);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
